id_operand_stage: RTL and testbench
===================================

# id_operand_stage

Decode-to-execute operand stage of the pipelined RV32 core. It drives the register file read addresses, resolves RAW hazards by forwarding from EX and MEM, inserts a one-cycle bubble on load-use, and holds or flushes the ID/EX pipeline register. It sits between the IF/ID register plus register file, and the EX stage. Write-back forwarding is not required: the register file writes on the falling clock edge, so a same-cycle WB value is already visible on `qa`/`qb`.

## Interface
Parameters:
- `CTRL_W`, 16, width of the opaque EX/MEM/WB control bundle passed through.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `d_valid`  in  1  IF/ID holds a real instruction.
- `d_rs1`, `d_rs2`  in  5  source register numbers.
- `d_use_rs1`, `d_use_rs2`  in  1  instruction actually reads rs1/rs2.
- `d_rd`  in  5  destination register.
- `d_wreg`  in  1  instruction writes rd.
- `d_is_load`  in  1  instruction is a load.
- `d_pc`, `d_imm`  in  32  PC and sign-extended immediate.
- `d_ctrl`  in  CTRL_W  control bundle.
- `rna`, `rnb`  out  5  register file read addresses (= `d_rs1`, `d_rs2`, combinational).
- `qa`, `qb`  in  32  register file read data (x0 reads 0).
- `ex_rd`, `ex_wreg`, `ex_is_load`, `ex_res`  in  5/1/1/32  instruction currently in EX.
- `mem_rd`, `mem_wreg`, `mem_res`  in  5/1/32  instruction in MEM (`mem_res` = load data or ALU result).
- `ex_busy`  in  1  EX multi-cycle unit is busy; the stage must hold.
- `flush`  in  1  taken branch/jump resolved in EX; kill the ID instruction.
- `stall`  out  1  freeze the PC and the IF/ID register this cycle.
- `e_valid`, `e_a`, `e_b`, `e_pc`, `e_imm`, `e_rd`, `e_wreg`, `e_is_load`, `e_ctrl`  out  registered ID/EX contents.
- `bubble_cnt`  out  32  count of load-use bubbles inserted.

## Operation
- Operand select per source: EX match if `ex_wreg`, `ex_rd != 0`, `ex_rd == rs`, and not `ex_is_load` → `ex_res`. Otherwise MEM match (same rule with `mem_*`) → `mem_res`. Otherwise `qa`/`qb`. EX takes priority over MEM. rs = 0 never forwards.
- Load-use hazard: `d_valid`, `ex_is_load`, `ex_wreg`, `ex_rd != 0`, and (`d_use_rs1` and `ex_rd == d_rs1`, or `d_use_rs2` and `ex_rd == d_rs2`).
- `stall` = !rst and (`ex_busy` or (load-use and !`flush`)).
- Register update priority at each edge:
  1. `rst`: all `e_*` 0, `bubble_cnt` 0.
  2. `flush`: bubble (e_valid=0, e_wreg=0, e_is_load=0, other fields don't-care/0).
  3. `ex_busy`: hold all `e_*`.
  4. load-use: bubble; `bubble_cnt` +1 (wraps at 2^32).
  5. else: load selected operands and the `d_*` fields; `e_valid`=`d_valid`, `e_wreg`=`d_wreg & d_valid`.
- `flush` overrides `ex_busy`. The EX unit is required to drop its busy state on a flush.

## Timing
- One-cycle latency from the ID inputs to the `e_*` outputs. `rna`/`rnb`/`stall` are combinational within the same cycle.
- A load-use hazard costs exactly one bubble. On the next cycle the load is in MEM and its value is forwarded from `mem_res`.
- `rst` asserted mid-stall clears state at the next edge. `stall` is 0 while `rst` is high.

## Structure
- Package `pipe_pkg` holds `XLEN`=32, `REG_W`=5, and the forward-select enum `FWD_RF`=0, `FWD_EX`=1, `FWD_MEM`=2.
- Sub-module `fwd_sel` takes rs, use, and the EX/MEM/RF sources, and returns the 32-bit operand and a load-use flag. It is instantiated twice, once per source.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs → all `e_*`=0, `bubble_cnt`=0, `stall`=0.
- EX forward: `d_rs1`=5; EX: rd=5, wreg, not load, `ex_res`=0x1234; `qa`=0xDEAD → next `e_a`=0x1234. Same with MEM rd=5, `mem_res`=0x55 → EX still wins.
- x0 guard: `d_rs2`=0; EX: rd=0, wreg, `ex_res`=7; `qb`=0 → `e_b`=0.
- Load-use: EX is a load to x3; ID `add x4,x3,x1` → `stall`=1 for one cycle, `e_valid`=0, `bubble_cnt`=1. Next cycle: `mem_res`=0x99 → `e_a`=0x99, `stall`=0.
- Flush vs. stall: load-use and `flush` in the same cycle → `stall`=0, bubble inserted, `bubble_cnt` unchanged.
- Busy hold: `ex_busy`=1 for 3 cycles with changing `d_*` → `e_*` frozen, `stall`=1. On release, the held ID instruction is loaded.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and forward-select encoding for the RV32 pipeline
package pipe_pkg;
   localparam int XLEN  = 32;
   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2
   } fwd_t;
endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - per-source operand forwarding mux and load-use detect
module fwd_sel
   import pipe_pkg::*;
(
   input  logic [REG_W-1:0] rs,
   input  logic             use_rs,
   input  logic [XLEN-1:0]  q_rf,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_wreg,
   input  logic             ex_is_load,
   input  logic [XLEN-1:0]  ex_res,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             mem_wreg,
   input  logic [XLEN-1:0]  mem_res,
   output logic [XLEN-1:0]  operand,
   output logic             load_use
);
   logic ex_hit;
   logic mem_hit;
   fwd_t sel;

   // A load in EX has no data yet; it is caught by load_use instead of forwarded.
   assign ex_hit   = ex_wreg && (ex_rd != '0) && (ex_rd == rs) && !ex_is_load;
   assign mem_hit  = mem_wreg && (mem_rd != '0) && (mem_rd == rs);
   assign load_use = use_rs && ex_wreg && ex_is_load && (ex_rd != '0) && (ex_rd == rs);

   always_comb begin
      sel = FWD_RF;
      if (ex_hit)
         sel = FWD_EX;
      else if (mem_hit)
         sel = FWD_MEM;
   end

   always_comb begin
      operand = q_rf;
      case (sel)
         FWD_EX:  operand = ex_res;
         FWD_MEM: operand = mem_res;
         default: operand = q_rf;
      endcase
   end
endmodule

// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - ID operand fetch, forwarding, hazard stall and ID/EX register
module id_operand_stage
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              d_valid,
   input  logic [REG_W-1:0]  d_rs1,
   input  logic [REG_W-1:0]  d_rs2,
   input  logic              d_use_rs1,
   input  logic              d_use_rs2,
   input  logic [REG_W-1:0]  d_rd,
   input  logic              d_wreg,
   input  logic              d_is_load,
   input  logic [XLEN-1:0]   d_pc,
   input  logic [XLEN-1:0]   d_imm,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic [REG_W-1:0]  rna,
   output logic [REG_W-1:0]  rnb,
   input  logic [XLEN-1:0]   qa,
   input  logic [XLEN-1:0]   qb,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              ex_wreg,
   input  logic              ex_is_load,
   input  logic [XLEN-1:0]   ex_res,
   input  logic [REG_W-1:0]  mem_rd,
   input  logic              mem_wreg,
   input  logic [XLEN-1:0]   mem_res,
   input  logic              ex_busy,
   input  logic              flush,
   output logic              stall,
   output logic              e_valid,
   output logic [XLEN-1:0]   e_a,
   output logic [XLEN-1:0]   e_b,
   output logic [XLEN-1:0]   e_pc,
   output logic [XLEN-1:0]   e_imm,
   output logic [REG_W-1:0]  e_rd,
   output logic              e_wreg,
   output logic              e_is_load,
   output logic [CTRL_W-1:0] e_ctrl,
   output logic [31:0]       bubble_cnt
);
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            lu_a;
   logic            lu_b;
   logic            load_use;

   assign rna = d_rs1;
   assign rnb = d_rs2;

   fwd_sel u_fwd_a (
      .rs(d_rs1), .use_rs(d_use_rs1), .q_rf(qa),
      .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .ex_res(ex_res),
      .mem_rd(mem_rd), .mem_wreg(mem_wreg), .mem_res(mem_res),
      .operand(op_a), .load_use(lu_a)
   );

   fwd_sel u_fwd_b (
      .rs(d_rs2), .use_rs(d_use_rs2), .q_rf(qb),
      .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .ex_res(ex_res),
      .mem_rd(mem_rd), .mem_wreg(mem_wreg), .mem_res(mem_res),
      .operand(op_b), .load_use(lu_b)
   );

   assign load_use = d_valid && (lu_a || lu_b);
   // A flush kills the ID instruction, so a pending load-use no longer needs the freeze.
   assign stall    = !rst && (ex_busy || (load_use && !flush));

   always_ff @(posedge clk) begin
      if (rst || flush || (!ex_busy && load_use)) begin
         e_valid   <= 1'b0;
         e_a       <= '0;
         e_b       <= '0;
         e_pc      <= '0;
         e_imm     <= '0;
         e_rd      <= '0;
         e_wreg    <= 1'b0;
         e_is_load <= 1'b0;
         e_ctrl    <= '0;
      end else if (!ex_busy) begin
         e_valid   <= d_valid;
         e_a       <= op_a;
         e_b       <= op_b;
         e_pc      <= d_pc;
         e_imm     <= d_imm;
         e_rd      <= d_rd;
         e_wreg    <= d_wreg && d_valid;
         e_is_load <= d_is_load;
         e_ctrl    <= d_ctrl;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         bubble_cnt <= '0;
      else if (!flush && !ex_busy && load_use)
         bubble_cnt <= bubble_cnt + 32'd1;
   end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb/tb_id_operand_stage.sv - randomized self-checking bench for id_operand_stage
module tb_id_operand_stage;
   localparam int CTRL_W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        d_valid, d_use_rs1, d_use_rs2, d_wreg, d_is_load;
   logic [4:0]  d_rs1, d_rs2, d_rd;
   logic [31:0] d_pc, d_imm;
   logic [CTRL_W-1:0] d_ctrl;
   logic [4:0]  rna, rnb;
   logic [31:0] qa, qb;
   logic [4:0]  ex_rd, mem_rd;
   logic        ex_wreg, ex_is_load, mem_wreg;
   logic [31:0] ex_res, mem_res;
   logic        ex_busy, flush, stall;
   logic        e_valid, e_wreg, e_is_load;
   logic [31:0] e_a, e_b, e_pc, e_imm;
   logic [4:0]  e_rd;
   logic [CTRL_W-1:0] e_ctrl;
   logic [31:0] bubble_cnt;

   id_operand_stage #(.CTRL_W(CTRL_W)) dut (
      .clk(clk), .rst(rst),
      .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
      .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
      .d_rd(d_rd), .d_wreg(d_wreg), .d_is_load(d_is_load),
      .d_pc(d_pc), .d_imm(d_imm), .d_ctrl(d_ctrl),
      .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
      .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .ex_res(ex_res),
      .mem_rd(mem_rd), .mem_wreg(mem_wreg), .mem_res(mem_res),
      .ex_busy(ex_busy), .flush(flush), .stall(stall),
      .e_valid(e_valid), .e_a(e_a), .e_b(e_b), .e_pc(e_pc), .e_imm(e_imm),
      .e_rd(e_rd), .e_wreg(e_wreg), .e_is_load(e_is_load), .e_ctrl(e_ctrl),
      .bubble_cnt(bubble_cnt)
   );

   int checks = 0;
   int errors = 0;

   // reference ID/EX contents
   logic        m_valid, m_wreg, m_load;
   logic [31:0] m_a, m_b, m_pc, m_imm, m_cnt;
   logic [4:0]  m_rd;
   logic [CTRL_W-1:0] m_ctrl;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Newest producer holding a usable value for rs wins; x0 is hardwired.
   function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rf);
      logic [4:0]  p_rd[2];
      logic        p_ok[2];
      logic [31:0] p_val[2];
      p_rd[0] = ex_rd;  p_ok[0] = ex_wreg && !ex_is_load; p_val[0] = ex_res;
      p_rd[1] = mem_rd; p_ok[1] = mem_wreg;               p_val[1] = mem_res;
      if (rs == 0) return rf;
      for (int i = 0; i < 2; i++)
         if (p_ok[i] && p_rd[i] == rs) return p_val[i];
      return rf;
   endfunction

   function automatic logic ref_hazard();
      if (!d_valid || !ex_is_load || !ex_wreg || ex_rd == 0) return 1'b0;
      return (d_use_rs1 && d_rs1 == ex_rd) || (d_use_rs2 && d_rs2 == ex_rd);
   endfunction

   task automatic model_clear();
      m_valid = 0; m_wreg = 0; m_load = 0; m_a = 0; m_b = 0;
      m_pc = 0; m_imm = 0; m_rd = 0; m_ctrl = 0;
   endtask

   // Inputs are already applied; check combinational outputs, clock once, check registers.
   task automatic step();
      logic hz;
      #1;
      hz = ref_hazard();
      check("rna", {27'd0, rna}, {27'd0, d_rs1});
      check("rnb", {27'd0, rnb}, {27'd0, d_rs2});
      check("stall", {31'd0, stall}, {31'd0, !rst && (ex_busy || (hz && !flush))});
      if (rst) begin
         model_clear(); m_cnt = 0;
      end else if (flush) begin
         model_clear();
      end else if (ex_busy) begin
      end else if (hz) begin
         model_clear(); m_cnt = m_cnt + 1;
      end else begin
         m_valid = d_valid; m_wreg = d_wreg && d_valid; m_load = d_is_load;
         m_a = ref_operand(d_rs1, qa); m_b = ref_operand(d_rs2, qb);
         m_pc = d_pc; m_imm = d_imm; m_rd = d_rd; m_ctrl = d_ctrl;
      end
      @(posedge clk);
      #1;
      check("e_valid", {31'd0, e_valid}, {31'd0, m_valid});
      check("e_wreg", {31'd0, e_wreg}, {31'd0, m_wreg});
      check("e_is_load", {31'd0, e_is_load}, {31'd0, m_load});
      check("e_a", e_a, m_a);
      check("e_b", e_b, m_b);
      check("e_pc", e_pc, m_pc);
      check("e_imm", e_imm, m_imm);
      check("e_rd", {27'd0, e_rd}, {27'd0, m_rd});
      check("e_ctrl", {16'd0, e_ctrl}, {16'd0, m_ctrl});
      check("bubble_cnt", bubble_cnt, m_cnt);
   endtask

   task automatic rand_inputs();
      d_valid = ($urandom_range(0, 7) != 0);
      d_rs1 = 5'($urandom_range(0, 4)); d_rs2 = 5'($urandom_range(0, 4));
      d_use_rs1 = $urandom; d_use_rs2 = $urandom;
      d_rd = 5'($urandom); d_wreg = $urandom; d_is_load = $urandom;
      d_pc = $urandom; d_imm = $urandom; d_ctrl = CTRL_W'($urandom);
      qa = $urandom; qb = $urandom;
      ex_rd = 5'($urandom_range(0, 4)); ex_wreg = $urandom; ex_is_load = ($urandom_range(0, 2) == 0);
      ex_res = $urandom;
      mem_rd = 5'($urandom_range(0, 4)); mem_wreg = $urandom; mem_res = $urandom;
      ex_busy = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rst = 0;
   endtask

   task automatic quiet_inputs();
      rand_inputs();
      ex_busy = 0; flush = 0; ex_wreg = 0; mem_wreg = 0; d_valid = 1;
   endtask

   initial begin
      m_cnt = 0;
      model_clear();

      // reset with random inputs
      rand_inputs(); rst = 1; step();
      rand_inputs(); rst = 1; step();
      check("reset_cnt", bubble_cnt, 32'd0);

      // EX forward, with MEM also matching
      quiet_inputs(); d_rs1 = 5; qa = 32'hDEAD;
      ex_rd = 5; ex_wreg = 1; ex_is_load = 0; ex_res = 32'h1234;
      mem_rd = 5; mem_wreg = 1; mem_res = 32'h55;
      step();
      check("ex_fwd", e_a, 32'h1234);

      // x0 never forwards
      quiet_inputs(); d_rs2 = 0; qb = 0;
      ex_rd = 0; ex_wreg = 1; ex_is_load = 0; ex_res = 7;
      step();
      check("x0_guard", e_b, 32'd0);

      // load-use: lw x3 in EX, add x4,x3,x1 in ID
      quiet_inputs(); d_rs1 = 3; d_rs2 = 1; d_use_rs1 = 1; d_use_rs2 = 1; d_rd = 4; d_wreg = 1;
      ex_rd = 3; ex_wreg = 1; ex_is_load = 1;
      step();
      check("lu_bubble", {31'd0, e_valid}, 32'd0);
      check("lu_cnt", bubble_cnt, 32'd1);
      ex_wreg = 0; ex_is_load = 0; mem_rd = 3; mem_wreg = 1; mem_res = 32'h99;
      step();
      check("lu_mem_fwd", e_a, 32'h99);

      // load-use with flush in the same cycle
      quiet_inputs(); d_rs1 = 2; d_use_rs1 = 1;
      ex_rd = 2; ex_wreg = 1; ex_is_load = 1; flush = 1;
      step();
      check("flush_cnt", bubble_cnt, 32'd1);

      // busy hold for 3 cycles, then release
      quiet_inputs(); step();
      for (int i = 0; i < 3; i++) begin
         quiet_inputs(); ex_busy = 1; step();
      end
      quiet_inputs(); d_pc = 32'hCAFE0000; step();
      check("busy_release_pc", e_pc, 32'hCAFE0000);

      // reset asserted while stalled
      quiet_inputs(); ex_busy = 1; rst = 1; step();

      // randomized run
      for (int n = 0; n < 2000; n++) begin
         rand_inputs();
         if ($urandom_range(0, 63) == 0) rst = 1;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
